// File: rtl/rvc_realign_queue_pkg.sv
// Shared definitions for the RV32C realign queue: length codes, RVC quadrant/funct3
// constants, RV32I opcodes and instruction encoders used by the expander.
package rvc_realign_queue_pkg;

    typedef enum logic {
        ST_EMPTY,
        ST_PEND
    } state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_c;
        logic        illegal;
    } entry_t;

    localparam logic [1:0] LEN32_CODE = 2'b11;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_SW       = 3'b110;
    localparam logic [2:0] C1_ADDI     = 3'b000;
    localparam logic [2:0] C1_JAL      = 3'b001;
    localparam logic [2:0] C1_LI       = 3'b010;
    localparam logic [2:0] C1_LUI      = 3'b011;
    localparam logic [2:0] C1_ALU      = 3'b100;
    localparam logic [2:0] C1_J        = 3'b101;
    localparam logic [2:0] C1_BEQZ     = 3'b110;
    localparam logic [2:0] C1_BNEZ     = 3'b111;
    localparam logic [2:0] C2_SLLI     = 3'b000;
    localparam logic [2:0] C2_LWSP     = 3'b010;
    localparam logic [2:0] C2_JR       = 3'b100;
    localparam logic [2:0] C2_SWSP     = 3'b110;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    function automatic logic is_rv32(input logic [1:0] low_bits);
        return low_bits == LEN32_CODE;
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_STORE};
    endfunction

    // Branch/jump encoders take the offset without its always-zero bit 0.
    function automatic logic [31:0] enc_b(input logic [11:0] imm_h, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm_h[11], imm_h[9:4], 5'd0, rs1, f3, imm_h[3:0], imm_h[10], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [19:0] imm_h, input logic [4:0] rd);
        return {imm_h[19], imm_h[9:0], imm_h[10], imm_h[18:11], rd, OP_JAL};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_OP};
    endfunction

endpackage

// File: rtl/rvc_realign_queue_expander.sv
// Combinational RV32C -> RV32I expander; reserved or unsupported encodings give
// illegal_o=1 with a zero instruction.
module rvc_expander
    import rvc_realign_queue_pkg::*;
(
    input  logic [15:0] c_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [11:0] imm6;
    logic [19:0] jimm;
    logic [11:0] bimm;
    logic [31:0] xw;
    logic        ill;

    assign rd   = c_i[11:7];
    assign rs2  = c_i[6:2];
    assign rdp  = {2'b01, c_i[4:2]};
    assign rs1p = {2'b01, c_i[9:7]};
    assign imm6 = {{7{c_i[12]}}, c_i[6:2]};
    assign jimm = {{10{c_i[12]}}, c_i[8], c_i[10:9], c_i[6], c_i[7], c_i[2], c_i[11], c_i[5:3]};
    assign bimm = {{5{c_i[12]}}, c_i[6:5], c_i[2], c_i[11:10], c_i[4:3]};

    assign instr_o   = ill ? '0 : xw;
    assign illegal_o = ill;

    always_comb begin
        xw  = '0;
        ill = 1'b0;
        case (c_i[1:0])
            Q0: begin
                case (c_i[15:13])
                    C0_ADDI4SPN: begin
                        ill = (c_i[12:5] == '0);
                        xw  = enc_i({2'b00, c_i[10:7], c_i[12:11], c_i[5], c_i[6], 2'b00},
                                    5'd2, F3_ADD, rdp, OP_IMM);
                    end
                    C0_LW: xw = enc_i({5'd0, c_i[5], c_i[12:10], c_i[6], 2'b00},
                                      rs1p, F3_W, rdp, OP_LOAD);
                    C0_SW: xw = enc_s({5'd0, c_i[5], c_i[12:10], c_i[6], 2'b00}, rdp, rs1p);
                    default: ill = 1'b1;
                endcase
            end
            Q1: begin
                case (c_i[15:13])
                    C1_ADDI: xw = enc_i(imm6, rd, F3_ADD, rd, OP_IMM);
                    C1_JAL:  xw = enc_j(jimm, 5'd1);
                    C1_LI:   xw = enc_i(imm6, 5'd0, F3_ADD, rd, OP_IMM);
                    C1_LUI: begin
                        ill = ({c_i[12], c_i[6:2]} == '0);
                        if (rd == 5'd2) begin
                            xw = enc_i({{3{c_i[12]}}, c_i[4:3], c_i[5], c_i[2], c_i[6], 4'b0000},
                                       5'd2, F3_ADD, 5'd2, OP_IMM);
                        end else begin
                            xw = {{15{c_i[12]}}, c_i[6:2], rd, OP_LUI};
                        end
                    end
                    C1_ALU: begin
                        case (c_i[11:10])
                            2'b00: begin
                                ill = c_i[12];
                                xw  = enc_i({F7_ZERO, c_i[6:2]}, rs1p, F3_SRL, rs1p, OP_IMM);
                            end
                            2'b01: begin
                                ill = c_i[12];
                                xw  = enc_i({F7_SUB, c_i[6:2]}, rs1p, F3_SRL, rs1p, OP_IMM);
                            end
                            2'b10: xw = enc_i(imm6, rs1p, F3_AND, rs1p, OP_IMM);
                            default: begin
                                // c[12]=1 selects subw/addw, which do not exist on RV32.
                                ill = c_i[12];
                                case (c_i[6:5])
                                    2'b00:   xw = enc_r(F7_SUB, rdp, rs1p, F3_ADD, rs1p);
                                    2'b01:   xw = enc_r(F7_ZERO, rdp, rs1p, F3_XOR, rs1p);
                                    2'b10:   xw = enc_r(F7_ZERO, rdp, rs1p, F3_OR, rs1p);
                                    default: xw = enc_r(F7_ZERO, rdp, rs1p, F3_AND, rs1p);
                                endcase
                            end
                        endcase
                    end
                    C1_J:    xw = enc_j(jimm, 5'd0);
                    C1_BEQZ: xw = enc_b(bimm, rs1p, F3_BEQ);
                    C1_BNEZ: xw = enc_b(bimm, rs1p, F3_BNE);
                    default: ill = 1'b1;
                endcase
            end
            Q2: begin
                case (c_i[15:13])
                    C2_SLLI: begin
                        ill = c_i[12];
                        xw  = enc_i({F7_ZERO, c_i[6:2]}, rd, F3_SLL, rd, OP_IMM);
                    end
                    C2_LWSP: begin
                        ill = (rd == '0);
                        xw  = enc_i({4'd0, c_i[3:2], c_i[12], c_i[6:4], 2'b00},
                                    5'd2, F3_W, rd, OP_LOAD);
                    end
                    C2_JR: begin
                        if (!c_i[12]) begin
                            if (rs2 == '0) begin
                                ill = (rd == '0);
                                xw  = enc_i(12'h000, rd, F3_ADD, 5'd0, OP_JALR);
                            end else begin
                                xw = enc_r(F7_ZERO, rs2, 5'd0, F3_ADD, rd);
                            end
                        end else if (rs2 == '0 && rd == '0) begin
                            xw = INSN_EBREAK;
                        end else if (rs2 == '0) begin
                            xw = enc_i(12'h000, rd, F3_ADD, 5'd1, OP_JALR);
                        end else begin
                            xw = enc_r(F7_ZERO, rs2, rd, F3_ADD, rd);
                        end
                    end
                    C2_SWSP: xw = enc_s({4'd0, c_i[8:7], c_i[12:9], 2'b00}, rs2, 5'd2);
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/rvc_realign_queue.sv
// Fetch-to-decode instruction buffer: splits fetch words into 16/32-bit instructions,
// stitches straddling 32-bit instructions, expands RVC and queues the results.
module rvc_realign_queue
    import rvc_realign_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter bit          ENABLE_RVC = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        flush,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_word,
    input  logic [31:0] fetch_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_is_c,
    output logic        out_illegal
);

    localparam int unsigned DEPTH_W = $clog2(DEPTH);
    localparam int unsigned CNT_W   = DEPTH_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    state_e               state_q, state_d;
    logic [15:0]          held_q, held_d;
    logic [31:0]          held_pc_q, held_pc_d;
    logic [DEPTH_W-1:0]   wr_q, wr_d, rd_q, rd_d, wr_p1;
    logic [CNT_W-1:0]     count_q, count_d;
    entry_t               mem_q [DEPTH];

    logic [15:0] lo_half, hi_half;
    logic [31:0] lo_pc, hi_pc;
    logic [31:0] lo_x, hi_x;
    logic        lo_ill, hi_ill;
    logic        lo_v, hi_v, hold_hi;
    entry_t      lo_e, hi_e, slot0, slot1;
    logic [1:0]  n_enq;
    logic        accept, deq, we0, we1;
    entry_t      head;

    assign lo_half = fetch_word[15:0];
    assign hi_half = fetch_word[31:16];
    assign lo_pc   = fetch_addr & 32'hFFFF_FFFC;
    assign hi_pc   = lo_pc | 32'h0000_0002;

    rvc_expander u_exp_lo (
        .c_i       (lo_half),
        .instr_o   (lo_x),
        .illegal_o (lo_ill)
    );

    rvc_expander u_exp_hi (
        .c_i       (hi_half),
        .instr_o   (hi_x),
        .illegal_o (hi_ill)
    );

    assign fetch_ready = rst_n && !flush && (count_q <= READY_MAX);
    assign out_valid   = (count_q != '0);
    assign accept      = fetch_valid && fetch_ready && rdy;
    assign deq         = out_valid && out_ready && rdy && !flush;
    assign wr_p1       = wr_q + DEPTH_W'(1);

    assign head        = mem_q[rd_q];
    assign out_instr   = out_valid ? head.instr   : '0;
    assign out_pc      = out_valid ? head.pc      : '0;
    assign out_is_c    = out_valid && head.is_c;
    assign out_illegal = out_valid && head.illegal;

    // Candidate entries for this fetch word, independent of whether it is accepted.
    always_comb begin
        lo_v    = 1'b0;
        hi_v    = 1'b0;
        hold_hi = 1'b0;
        lo_e    = '0;
        hi_e    = '{instr: hi_x, pc: hi_pc, is_c: 1'b1, illegal: hi_ill};
        if (!ENABLE_RVC) begin
            lo_v = 1'b1;
            lo_e = '{instr: fetch_word, pc: fetch_addr, is_c: 1'b0, illegal: 1'b0};
        end else begin
            if (state_q == ST_PEND) begin
                lo_v = 1'b1;
                lo_e = '{instr: {lo_half, held_q}, pc: held_pc_q, is_c: 1'b0, illegal: 1'b0};
            end else if (!fetch_addr[1]) begin
                lo_v = 1'b1;
                if (is_rv32(lo_half[1:0])) begin
                    lo_e = '{instr: fetch_word, pc: lo_pc, is_c: 1'b0, illegal: 1'b0};
                end else begin
                    lo_e = '{instr: lo_x, pc: lo_pc, is_c: 1'b1, illegal: lo_ill};
                end
            end
            if (state_q == ST_PEND || fetch_addr[1] || !is_rv32(lo_half[1:0])) begin
                hold_hi = is_rv32(hi_half[1:0]);
                hi_v    = !hold_hi;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        held_pc_d = held_pc_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        n_enq     = '0;
        slot0     = lo_v ? lo_e : hi_e;
        slot1     = hi_e;
        if (rdy) begin
            if (flush) begin
                state_d   = ST_EMPTY;
                held_d    = '0;
                held_pc_d = '0;
                wr_d      = '0;
                rd_d      = '0;
                count_d   = '0;
            end else begin
                if (accept) begin
                    n_enq = {1'b0, lo_v} + {1'b0, hi_v};
                    if (hold_hi) begin
                        state_d   = ST_PEND;
                        held_d    = hi_half;
                        held_pc_d = hi_pc;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                wr_d    = wr_q + DEPTH_W'(n_enq);
                rd_d    = rd_q + DEPTH_W'(deq);
                count_d = count_q + CNT_W'(n_enq) - CNT_W'(deq);
            end
        end
    end

    assign we0 = (n_enq != 2'd0);
    assign we1 = (n_enq == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            held_q    <= '0;
            held_pc_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            held_pc_q <= held_pc_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem_q[wr_q] <= slot0;
        if (we1) mem_q[wr_p1] <= slot1;
    end

endmodule

// File: tb/tb_rvc_realign_queue.sv
// Directed bench for rvc_realign_queue: expected entries are queued at issue time and
// compared by an independent monitor whenever the decoder-side handshake fires.
module tb_rvc_realign_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_c;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_word = '0;
    logic [31:0] fetch_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_c;
    logic        out_illegal;

    always #5 clk = ~clk;

    rvc_realign_queue #(.DEPTH(4), .ENABLE_RVC(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_word  (fetch_word),
        .fetch_addr  (fetch_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_is_c    (out_is_c),
        .out_illegal (out_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic expect_e(input logic [31:0] pc, input logic [31:0] instr,
                            input logic is_c, input logic ill);
        exp_t e;
        e.pc = pc; e.instr = instr; e.is_c = is_c; e.ill = ill;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is taken.
    task automatic send(input logic [31:0] w, input logic [31:0] a);
        int unsigned t = 0;
        fetch_word  = w;
        fetch_addr  = a;
        fetch_valid = 1'b1;
        @(negedge clk);
        while (!fetch_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!fetch_ready) begin
            n_checks++;
            $display("FAIL send_timeout: fetch_ready stuck low for word at 0x%08h", a);
        end
        @(posedge clk);
        #1 fetch_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            #1 t++;
        end
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries outstanding, expected 0", sb.size());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rdy && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: pc 0x%08h instr 0x%08h, expected no entry",
                             out_pc, out_instr);
                end else begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    check("out_is_c", {31'd0, out_is_c}, {31'd0, e.is_c});
                    check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #2;
        check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_flags", {30'd0, out_is_c, out_illegal}, 32'd0);
        #10 rst_n = 1'b1;
        tick();

        // Two compressed instructions in one word; registered output one cycle later.
        expect_e(32'h100, 32'h0015_0513, 1'b1, 1'b0);
        expect_e(32'h102, 32'h0000_8067, 1'b1, 1'b0);
        send(32'h8082_0505, 32'h100);
        @(negedge clk);
        check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        check("t1_ready_cnt2", {31'd0, fetch_ready}, 32'd1);
        tick();
        out_ready = 1'b1;
        drain();

        // 32-bit instruction straddling two fetch words.
        expect_e(32'h200, 32'h0015_0513, 1'b1, 1'b0);
        expect_e(32'h202, 32'h0015_0513, 1'b0, 1'b0);
        expect_e(32'h206, 32'h0000_0013, 1'b1, 1'b0);
        send(32'h0513_0505, 32'h200);
        send(32'h0001_0015, 32'h204);
        drain();

        expect_e(32'h400, 32'h0, 1'b1, 1'b1);
        expect_e(32'h402, 32'h0, 1'b1, 1'b1);
        send(32'h0000_0000, 32'h400);

        expect_e(32'h500, 32'hFFF0_0513, 1'b1, 1'b0);
        expect_e(32'h502, 32'h0045_A503, 1'b1, 1'b0);
        send(32'h41C8_557D, 32'h500);
        expect_e(32'h504, 32'h00B0_0533, 1'b1, 1'b0);
        expect_e(32'h506, 32'h0005_0463, 1'b1, 1'b0);
        send(32'hC501_852E, 32'h504);
        expect_e(32'h508, 32'h0, 1'b1, 1'b1);
        expect_e(32'h50A, 32'h0, 1'b1, 1'b1);
        send(32'h6501_1506, 32'h508);
        expect_e(32'h50C, 32'h00A5_0533, 1'b0, 1'b0);
        send(32'h00A5_0533, 32'h50C);
        drain();

        // Flush while a straddling half is held; the next redirect must not stitch it.
        out_ready = 1'b0;
        send(32'h0513_0505, 32'h600);
        flush       = 1'b1;
        out_ready   = 1'b1;
        fetch_valid = 1'b1;
        fetch_word  = 32'h8082_0505;
        fetch_addr  = 32'h604;
        @(negedge clk);
        check("flush_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("flush_empty", {31'd0, out_valid}, 32'd0);
        tick();
        expect_e(32'h302, 32'h0000_8067, 1'b1, 1'b0);
        send(32'h8082_0000, 32'h302);
        drain();

        // Backpressure with DEPTH=4.
        out_ready = 1'b0;
        expect_e(32'h700, 32'h0015_0513, 1'b1, 1'b0);
        expect_e(32'h702, 32'h0000_8067, 1'b1, 1'b0);
        expect_e(32'h704, 32'h0015_0513, 1'b1, 1'b0);
        expect_e(32'h706, 32'h0000_8067, 1'b1, 1'b0);
        send(32'h8082_0505, 32'h700);
        send(32'h8082_0505, 32'h704);
        @(negedge clk);
        check("bp_full_not_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_cnt3_not_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_cnt2_ready", {31'd0, fetch_ready}, 32'd1);
        tick();
        out_ready = 1'b1;
        drain();

        // rdy low freezes queue and handshakes.
        out_ready = 1'b0;
        expect_e(32'h800, 32'h0015_0513, 1'b1, 1'b0);
        expect_e(32'h802, 32'h0000_8067, 1'b1, 1'b0);
        send(32'h8082_0505, 32'h800);
        rdy         = 1'b0;
        out_ready   = 1'b1;
        fetch_valid = 1'b1;
        fetch_word  = 32'h0000_0000;
        fetch_addr  = 32'h804;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_valid", {31'd0, out_valid}, 32'd1);
            check("frz_pc", out_pc, 32'h800);
            @(posedge clk);
        end
        #1 rdy = 1'b1;
        fetch_valid = 1'b0;
        drain();

        // rdy low while a half is held keeps the realign state.
        expect_e(32'h900, 32'h0015_0513, 1'b1, 1'b0);
        send(32'h0513_0505, 32'h900);
        rdy         = 1'b0;
        fetch_valid = 1'b1;
        fetch_word  = 32'h8082_0000;
        fetch_addr  = 32'h906;
        repeat (3) tick();
        rdy         = 1'b1;
        fetch_valid = 1'b0;
        expect_e(32'h902, 32'h0015_0513, 1'b0, 1'b0);
        expect_e(32'h906, 32'h0000_0013, 1'b1, 1'b0);
        send(32'h0001_0015, 32'h904);
        drain();

        // Asynchronous reset mid-stream with a held half.
        out_ready = 1'b0;
        send(32'h0513_0505, 32'hA00);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        check("midrst_out_instr", out_instr, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        expect_e(32'hB00, 32'h0015_0513, 1'b1, 1'b0);
        expect_e(32'hB02, 32'h0000_8067, 1'b1, 1'b0);
        send(32'h8082_0505, 32'hB00);
        drain();

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
